// File: rtl/led_arbiter.sv
// Round-robin arbiter handing a 4-LED bank to one of three requesters in tick-based time slices.
// Optional macro LED_ARB_PRIO_EN gives requester 0 priority in IDLE and lets it preempt owners 1/2 on a tick.
module led_arbiter #(
  parameter int CNT_MAX     = 24_999_999,
  parameter int SLICE_TICKS = 4
) (
  input  logic       clk_50mhz,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic [3:0] pat0,
  input  logic [3:0] pat1,
  input  logic [3:0] pat2,
  output logic [2:0] gnt,
  output logic [3:0] leds,
  output logic       busy
);

  localparam int CW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CW-1:0] CNT_TERM   = CW'(CNT_MAX);
  localparam logic [7:0]    SLICE_LAST = 8'(SLICE_TICKS - 1);

  typedef enum logic [1:0] {IDLE, GRANT, GUARD} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic          tick;
  logic [1:0]    owner, owner_next;
  logic [1:0]    ptr, ptr_next;
  logic [7:0]    slice, slice_next;
  logic          guard_first, guard_first_next;
  logic [2:0]    gnt_next;
  logic [3:0]    leds_next;
  logic [3:0]    owner_pat;
  logic [1:0]    cand1, cand2, pick;
  logic          pick_valid;
  logic          others_req;
  logic          slice_end;
  logic          prio_preempt;

  assign tick       = (cnt == CNT_TERM);
  assign busy       = (state != IDLE);
  assign others_req = |(req & ~(3'b001 << owner));
  assign slice_end  = (slice == SLICE_LAST) && others_req;

`ifdef LED_ARB_PRIO_EN
  assign prio_preempt = (owner != 2'd0) && req[0];
`else
  assign prio_preempt = 1'b0;
`endif

  // Search order starts just after the last owner and wraps 2 -> 0.
  always_comb begin
    cand1      = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
    cand2      = (cand1 == 2'd2) ? 2'd0 : cand1 + 2'd1;
    pick_valid = |req;
    if (req[cand1])      pick = cand1;
    else if (req[cand2]) pick = cand2;
    else                 pick = ptr;
`ifdef LED_ARB_PRIO_EN
    if (req[0]) pick = 2'd0;
`endif
  end

  always_comb begin
    case (owner)
      2'd0:    owner_pat = pat0;
      2'd1:    owner_pat = pat1;
      2'd2:    owner_pat = pat2;
      default: owner_pat = 4'b0000;
    endcase
  end

  always_comb begin
    state_next       = state;
    owner_next       = owner;
    ptr_next         = ptr;
    slice_next       = slice;
    guard_first_next = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_next = GRANT;
          owner_next = pick;
          ptr_next   = pick;
          slice_next = 8'd0;
        end
      end
      GRANT: begin
        // Owner drop wins over slice expiry; both land in GUARD anyway.
        if (!req[owner]) begin
          state_next       = GUARD;
          guard_first_next = 1'b1;
        end else if (tick && (prio_preempt || slice_end)) begin
          state_next       = GUARD;
          guard_first_next = 1'b1;
        end else if (tick) begin
          slice_next = (slice == SLICE_LAST) ? 8'd0 : slice + 8'd1;
        end
      end
      GUARD: begin
        // A tick in the very first guard cycle is ignored so the gap spans a full tick period.
        if (tick && !guard_first) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign gnt_next  = (state_next == GRANT) ? (3'b001 << owner_next) : 3'b000;
  assign leds_next = ((state == GRANT) && (state_next == GRANT)) ? owner_pat : 4'b0000;

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      cnt         <= '0;
      state       <= IDLE;
      owner       <= 2'd0;
      ptr         <= 2'd2;
      slice       <= 8'd0;
      guard_first <= 1'b0;
      gnt         <= 3'b000;
      leds        <= 4'b0000;
    end else begin
      cnt         <= tick ? '0 : cnt + CW'(1);
      state       <= state_next;
      owner       <= owner_next;
      ptr         <= ptr_next;
      slice       <= slice_next;
      guard_first <= guard_first_next;
      gnt         <= gnt_next;
      leds        <= leds_next;
    end
  end

endmodule

// File: tb/tb_led_arbiter.sv
// Scoreboard bench for led_arbiter: a tick/ownership reference model queues expected outputs per cycle,
// an independent monitor compares them against the DUT one cycle later.
module tb_led_arbiter;

  localparam int CNT_MAX     = 4;
  localparam int SLICE_TICKS = 2;

  logic       clk_50mhz = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req = 3'b000;
  logic [3:0] pat0 = 4'h0;
  logic [3:0] pat1 = 4'h0;
  logic [3:0] pat2 = 4'h0;
  logic [2:0] gnt;
  logic [3:0] leds;
  logic       busy;

  always #5 clk_50mhz = ~clk_50mhz;

  led_arbiter #(.CNT_MAX(CNT_MAX), .SLICE_TICKS(SLICE_TICKS)) dut (
    .clk_50mhz(clk_50mhz),
    .rst(rst),
    .req(req),
    .pat0(pat0),
    .pat1(pat1),
    .pat2(pat2),
    .gnt(gnt),
    .leds(leds),
    .busy(busy)
  );

  typedef struct packed {
    logic [2:0] gnt;
    logic [3:0] leds;
    logic       busy;
  } expect_t;

  expect_t expq[$];
  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Reference model: ownership, ticks held, and the edge at which the guard gap began.
  int m_owner = -1;
  int m_last = 2;
  int m_held = 0;
  int m_cyc = 0;
  int m_edge = 0;
  int m_guard_start = 0;
  bit m_guard = 1'b0;

  task automatic modelEdge(input logic r, input logic [2:0] rq,
                           input logic [3:0] p0, input logic [3:0] p1, input logic [3:0] p2,
                           output expect_t e);
    logic [3:0] pats [3];
    bit tick;
    bit release_now;
    int pick;
    pats = '{p0, p1, p2};
    e = '0;
    m_edge++;
    if (r) begin
      m_owner = -1;
      m_guard = 1'b0;
      m_last  = 2;
      m_cyc   = 0;
      m_held  = 0;
      return;
    end
    tick = ((m_cyc % (CNT_MAX + 1)) == CNT_MAX);
    m_cyc++;
    if (m_guard) begin
      if (tick && (m_edge > m_guard_start + 1)) m_guard = 1'b0;
      e.busy = m_guard;
    end else if (m_owner < 0) begin
      pick = -1;
      for (int k = 1; k <= 3; k++)
        if (pick < 0 && rq[(m_last + k) % 3]) pick = (m_last + k) % 3;
`ifdef LED_ARB_PRIO_EN
      if (rq[0]) pick = 0;
`endif
      if (pick >= 0) begin
        m_owner = pick;
        m_last  = pick;
        m_held  = 0;
        e.gnt   = 3'(1 << pick);
        e.busy  = 1'b1;
      end
    end else begin
      release_now = !rq[m_owner];
      if (!release_now && tick) begin
        m_held++;
`ifdef LED_ARB_PRIO_EN
        if (m_owner != 0 && rq[0]) release_now = 1'b1;
`endif
        if ((m_held % SLICE_TICKS) == 0 && (rq & ~(3'(1 << m_owner))) != 3'b000) release_now = 1'b1;
      end
      e.busy = 1'b1;
      if (release_now) begin
        m_owner       = -1;
        m_guard       = 1'b1;
        m_guard_start = m_edge;
      end else begin
        e.gnt  = 3'(1 << m_owner);
        e.leds = pats[m_owner];
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [2:0] rq,
                               input logic [3:0] p0, input logic [3:0] p1, input logic [3:0] p2);
    expect_t e;
    @(negedge clk_50mhz);
    rst  = r;
    req  = rq;
    pat0 = p0;
    pat1 = p1;
    pat2 = p2;
    modelEdge(r, rq, p0, p1, p2, e);
    expq.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %b expected %b", name, cycle, actual, expected);
    end
  endtask

  initial begin : monitor
    expect_t e;
    forever begin
      @(posedge clk_50mhz);
      #1;
      cycle++;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        checkOutput("gnt", {1'b0, gnt}, {1'b0, e.gnt});
        checkOutput("leds", leds, e.leds);
        checkOutput("busy", {3'b000, busy}, {3'b000, e.busy});
        checkOutput("gnt_onehot", {3'b000, ($countones(gnt) <= 1)}, 4'b0001);
      end
    end
  end

  initial begin : stimulus
    logic [2:0] r_req;
    logic [3:0] r0, r1, r2;
    logic       r_rst;
    $display("[TB] reset phase");
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 3'b111, 4'hF, 4'hF, 4'hF);

    $display("[TB] single requester");
    for (int i = 0; i < 60; i++) applyStimulus(1'b0, 3'b010, 4'h0, 4'b1010, 4'h0);

    $display("[TB] round robin");
    applyStimulus(1'b1, 3'b000, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 90; i++) applyStimulus(1'b0, 3'b111, 4'b0001, 4'b0010, 4'b0100);

    $display("[TB] early release");
    applyStimulus(1'b1, 3'b000, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 3'b010, 4'b0001, 4'b0010, 4'b0100);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 3'b110, 4'b0001, 4'b0010, 4'b0100);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 3'b100, 4'b0001, 4'b0010, 4'b0100);

    $display("[TB] requester 0 arrives during owner 2");
    applyStimulus(1'b1, 3'b000, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 3'b100, 4'b0011, 4'b0110, 4'b1100);
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 3'b101, 4'b0011, 4'b0110, 4'b1100);

    $display("[TB] reset mid-grant");
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 3'b111, 4'h9, 4'h6, 4'hC);
    applyStimulus(1'b1, 3'b111, 4'h9, 4'h6, 4'hC);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 3'b111, 4'h9, 4'h6, 4'hC);

    $display("[TB] random traffic");
    r_req = 3'b000;
    r0 = 4'h0;
    r1 = 4'h0;
    r2 = 4'h0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 11) == 0) r_req = 3'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        r0 = 4'($urandom);
        r1 = 4'($urandom);
        r2 = 4'($urandom);
      end
      r_rst = ($urandom_range(0, 299) == 0);
      applyStimulus(r_rst, r_req, r0, r1, r2);
    end

    repeat (3) @(posedge clk_50mhz);
    #2;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
